// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin select arbiter.
// Keeps select-width and modulo-increment logic in one place so every N agrees.
package rr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // Index width for N requesters; never narrower than one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Increment modulo n without relying on power-of-two wrap.
  function automatic int unsigned rot_next(input int unsigned p, input int unsigned n);
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/rr_sel_arbiter_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = sel_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             found_o,
  output logic [SEL_W-1:0] winner_o
);

  logic [N-1:0] rot;
  logic         hit;
  int unsigned  off;
  int unsigned  sum;

  always_comb begin
    // Rotating a doubled copy puts channel ptr at bit 0 with wraparound built in.
    rot = N'({req_i, req_i} >> ptr_i);
    hit = 1'b0;
    off = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (rot[i] && !hit) begin
        hit = 1'b1;
        off = i;
      end
    end
    sum = 32'(ptr_i) + off;
    if (sum >= N) sum = sum - N;
    found_o  = hit;
    winner_o = SEL_W'(sum);
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving a Mux select, with a sticky valid/ready grant.
module rr_sel_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned SEL_W = sel_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic             grant_valid,
  output logic [SEL_W-1:0] grant_sel,
  output logic [N-1:0]     grant_onehot,
  input  logic             grant_ready
);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N-1:0]     onehot_q, onehot_d;
  logic             load;
  logic             found;
  logic [SEL_W-1:0] winner;

  rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .found_o  (found),
    .winner_o (winner)
  );

  assign load = (state_q == IDLE) || grant_ready;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    onehot_d = onehot_q;
    if (load) begin
      if (found) begin
        state_d  = HOLD;
        sel_d    = winner;
        onehot_d = N'(1) << winner;
        ptr_d    = SEL_W'(rot_next(32'(winner), N));
      end else begin
        // Nothing to grant: drop valid but leave sel and ptr where they were.
        state_d  = IDLE;
        onehot_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      onehot_q <= onehot_d;
    end
  end

  assign grant_valid  = (state_q == HOLD);
  assign grant_sel    = sel_q;
  assign grant_onehot = onehot_q;

endmodule

// File: doc/rr_sel_arbiter.md
Name: rr_sel_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the parameterised N-input Mux and drives its select input.
- Takes N request lines and issues one registered grant, as an index (connects to Mux sel) plus a one-hot copy.
- Holds each grant stable under a valid/ready handshake until the downstream consumer accepts it.
- Arbitration is fair: after a channel wins, it drops to lowest priority.

Parameters:
- N, 4, number of requesters; must equal the Mux input count; legal range 2..64.
- SEL_W, $clog2(N), width of grant_sel; derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request vector; bit i = channel i has data.
- grant_valid  output  1  a grant is held and presented.
- grant_sel  output  SEL_W  index of the granted channel; drives Mux sel.
- grant_onehot  output  N  one-hot form of grant_sel; all zero when grant_valid=0.
- grant_ready  input  1  consumer accepts the current grant this cycle.

Behaviour:
- Reset (rst_n=0, asynchronous): grant_valid=0, grant_sel=0, grant_onehot=0, ptr=0. No output toggles while in reset.
- Internal state:
  - ptr [SEL_W-1:0] is the highest-priority channel for the next arbitration.
  - Two states: IDLE (grant_valid=0) and HOLD (grant_valid=1).
- Load condition: load = !grant_valid || grant_ready. Evaluated every cycle.
- On load with |req=1:
  - winner = first set bit of req scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Next edge: grant_sel=winner, grant_onehot=1<<winner, grant_valid=1, ptr=(winner+1) mod N. Go to or stay in HOLD.
- On load with req=0: next edge grant_valid=0, grant_onehot=0, grant_sel unchanged, ptr unchanged. Go to IDLE.
- HOLD with grant_ready=0: all outputs and ptr frozen, even if req changes or the granted bit drops. The grant is sticky so the Mux output stays stable.
- Latency: 1 cycle from req asserted (in IDLE) to grant_valid=1.
- Back-to-back: a handshake (valid&&ready) in cycle t with other requests pending yields the next grant at edge t+1. No bubble.
- Re-grant: if the winner still requests and is the only requester, it is granted again on the next load.
- Wrap-around: ptr=N-1 wraps to 0. Modulo arithmetic must be explicit for non-power-of-2 N; for N=3, ptr never equals 3.
- grant_ready while grant_valid=0 is ignored, apart from having no effect on load (load is already 1).
- Reset mid-HOLD: grant is dropped immediately. After release, arbitration restarts from ptr=0.
- Invariants:
  - $onehot0(grant_onehot).
  - grant_onehot == (grant_valid ? 1<<grant_sel : 0).
  - A requester that holds req continuously is granted within N grants.

Decomposition:
- Package rr_arb_pkg holds:
  - a localparam function for the SEL_W calculation, safe for N=2;
  - the enum arb_state_t {IDLE, HOLD};
  - a function rot_next(ptr, N) implementing modulo increment.
- Sub-module rr_pick: purely combinational. Inputs req and ptr; outputs found and winner. Implemented as a double-width rotate plus priority encoder.
- The top module owns the state register, ptr, output registers and handshake logic.

Test Plan:
- Reset and idle: rst_n=0 for 3 cycles, then req=0 for 5 cycles -> grant_valid=0, grant_onehot=4'b0000 throughout.
- Single requester: req=4'b0100 held, grant_ready=1 -> grant_sel=2 one cycle after req; re-granted every cycle; ptr alternates 3 then stays at 3.
- Fair rotation: req=4'b1111, grant_ready=1 -> grant_sel sequence 0,1,2,3,0,1 with no bubbles.
- Back-pressure and sticky grant:
  - req=4'b1010, grant_ready=0 for 4 cycles -> grant_sel=1 held.
  - Drop req[1] mid-hold -> grant_sel still 1.
  - Raise ready -> next grant_sel=3.
- Wrap-around: ptr=3 (after granting ch2), req=4'b0001 -> grant_sel=0, ptr becomes 1. Repeat with N=3 to check mod-3 wrap.
- Reset mid-HOLD, Mux integration:
  - Assert rst_n=0 while grant_sel=2 -> grant_valid falls without waiting for a clock edge.
  - After release with req=4'b1100 -> grant_sel=2, since ptr=0.
  - Connect the Mux #(8,4): y equals a[grant_sel] whenever grant_valid=1.
